// File: rtl/bus_arbiter2.sv
// bus_arbiter2: two-requester round-robin arbiter onto one downstream port with a timeout watchdog.
module bus_arbiter2 #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  input  logic        m0_ren,
  input  logic        m0_wen,
  output logic [31:0] m0_rdata,
  output logic        m0_done,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  input  logic        m1_ren,
  input  logic        m1_wen,
  output logic [31:0] m1_rdata,
  output logic        m1_done,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wmask,
  output logic        s_ren,
  output logic        s_wen,
  input  logic [31:0] s_rdata,
  input  logic        s_done,
  output logic        busy,
  output logic        grant_id,
  output logic        err,
  output logic [31:0] err_addr,
  input  logic        err_clr
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [15:0] CNT_MAX = 16'(TIMEOUT_CYCLES - 1);
  state_t state, state_n;
  logic owner, owner_n, last_owner, last_owner_n, err_q, err_n, fin;
  logic [15:0] cnt, cnt_n;
  logic [31:0] err_addr_q, err_addr_n, rdata, o_addr, o_wdata;
  logic [3:0] o_wmask;
  logic req0, req1, o_ren, o_wen;
  assign req0 = m0_ren | m0_wen;
  assign req1 = m1_ren | m1_wen;
  assign o_addr = owner ? m1_addr : m0_addr;
  assign o_wdata = owner ? m1_wdata : m0_wdata;
  assign o_wmask = owner ? m1_wmask : m0_wmask;
  assign o_ren = owner ? m1_ren : m0_ren;
  assign o_wen = owner ? m1_wen : m0_wen;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      last_owner <= 1'b1;
      cnt <= '0;
      err_q <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      last_owner <= last_owner_n;
      cnt <= cnt_n;
      err_q <= err_n;
      err_addr_q <= err_addr_n;
    end
  end
  always_comb begin
    state_n = state;
    owner_n = owner;
    last_owner_n = last_owner;
    cnt_n = cnt;
    err_n = err_q & ~err_clr;
    err_addr_n = err_addr_q;
    s_addr = '0;
    s_wdata = '0;
    s_wmask = '0;
    s_ren = 1'b0;
    s_wen = 1'b0;
    fin = 1'b0;
    rdata = '0;
    if (state == IDLE) begin
      if (req0 | req1) begin
        state_n = BUSY;
        owner_n = (req0 & req1) ? ~last_owner : req1;
        cnt_n = '0;
      end
    end else begin
      s_addr = o_addr;
      s_wdata = o_wdata;
      s_wmask = o_wmask;
      s_ren = o_ren;
      s_wen = o_wen;
      if (!(o_ren | o_wen)) begin
        state_n = IDLE;
        last_owner_n = owner;
      end else if (s_done) begin
        fin = 1'b1;
        rdata = s_rdata;
        state_n = IDLE;
        last_owner_n = owner;
      end else if (cnt == CNT_MAX) begin
        fin = 1'b1;
        rdata = ERR_RDATA;
        s_ren = 1'b0;
        s_wen = 1'b0;
        err_n = 1'b1;
        err_addr_n = o_addr;
        state_n = IDLE;
        last_owner_n = owner;
      end else begin
        cnt_n = cnt + 16'd1;
      end
    end
    // reset silences every output immediately, so an in-flight transaction never completes
    if (rst) begin
      s_addr = '0;
      s_wdata = '0;
      s_wmask = '0;
      s_ren = 1'b0;
      s_wen = 1'b0;
      fin = 1'b0;
    end
  end
  assign m0_done = fin & ~owner;
  assign m1_done = fin & owner;
  assign m0_rdata = m0_done ? rdata : '0;
  assign m1_rdata = m1_done ? rdata : '0;
  assign busy = (state == BUSY) & ~rst;
  assign grant_id = owner & ~rst;
  assign err = err_q & ~rst;
  assign err_addr = rst ? '0 : err_addr_q;
endmodule

// File: tb/tb_bus_arbiter2.sv
// tb_bus_arbiter2: directed scenario tests for bus_arbiter2 with a 4-cycle timeout.
module tb_bus_arbiter2;
  logic clk = 1'b0, rst;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [3:0] m0_wmask, m1_wmask, s_wmask;
  logic m0_ren, m0_wen, m0_done, m1_ren, m1_wen, m1_done;
  logic [31:0] s_addr, s_wdata, s_rdata, err_addr;
  logic s_ren, s_wen, s_done, busy, grant_id, err, err_clr;
  int total = 0, bad = 0;
  bus_arbiter2 #(.TIMEOUT_CYCLES(4), .ERR_RDATA(32'hDEADBEEF)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_ren(m0_ren), .m0_wen(m0_wen),
    .m0_rdata(m0_rdata), .m0_done(m0_done),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_ren(m1_ren), .m1_wen(m1_wen),
    .m1_rdata(m1_rdata), .m1_done(m1_done),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wmask(s_wmask), .s_ren(s_ren), .s_wen(s_wen),
    .s_rdata(s_rdata), .s_done(s_done),
    .busy(busy), .grant_id(grant_id), .err(err), .err_addr(err_addr), .err_clr(err_clr)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic smp();
    @(negedge clk);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    m0_addr = 0; m0_wdata = 0; m0_wmask = 0; m0_ren = 0; m0_wen = 0;
    m1_addr = 0; m1_wdata = 0; m1_wmask = 0; m1_ren = 0; m1_wen = 0;
    s_rdata = 0; s_done = 0; err_clr = 0;
    cyc();
    cyc();
    smp();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    total++; if (grant_id !== 1'b0) begin bad++; $display("FAIL reset_grant got=%0h exp=0", grant_id); end
    total++; if (err !== 1'b0 || err_addr !== 32'h0) begin bad++; $display("FAIL reset_err got=%0h/%h exp=0/0", err, err_addr); end
    total++; if (s_ren !== 1'b0 || s_wen !== 1'b0 || s_addr !== 32'h0) begin bad++; $display("FAIL reset_s got=%0h/%0h/%h exp=0", s_ren, s_wen, s_addr); end
    cyc();
  endtask
  task automatic test_read();
    rst = 1'b0;
    m0_addr = 32'h100; m0_wdata = 32'h11111111; m0_wmask = 4'hF; m0_ren = 1'b1;
    m1_addr = 32'h999; m1_wdata = 32'h22222222;
    smp();
    total++; if (busy !== 1'b0 || s_ren !== 1'b0 || s_addr !== 32'h0) begin bad++; $display("FAIL read_idle got=%0h/%0h/%h exp=0/0/0", busy, s_ren, s_addr); end
    cyc();
    for (int i = 1; i <= 3; i++) begin
      if (i == 3) begin s_done = 1'b1; s_rdata = 32'h12345678; end
      smp();
      total++; if (busy !== 1'b1 || grant_id !== 1'b0 || s_ren !== 1'b1) begin bad++; $display("FAIL read_busy%0d got=%0h/%0h/%0h exp=1/0/1", i, busy, grant_id, s_ren); end
      total++; if (s_addr !== 32'h100 || s_wdata !== 32'h11111111 || s_wmask !== 4'hF) begin bad++; $display("FAIL read_fwd%0d got=%h/%h/%h exp=100/11111111/f", i, s_addr, s_wdata, s_wmask); end
      total++; if (m1_done !== 1'b0 || m1_rdata !== 32'h0) begin bad++; $display("FAIL read_m1_%0d got=%0h/%h exp=0/0", i, m1_done, m1_rdata); end
      if (i < 3) begin
        total++; if (m0_done !== 1'b0 || m0_rdata !== 32'h0) begin bad++; $display("FAIL read_early%0d got=%0h/%h exp=0/0", i, m0_done, m0_rdata); end
      end else begin
        total++; if (m0_done !== 1'b1 || m0_rdata !== 32'h12345678) begin bad++; $display("FAIL read_done got=%0h/%h exp=1/12345678", m0_done, m0_rdata); end
      end
      cyc();
    end
    m0_ren = 1'b0; s_done = 1'b0;
    smp();
    total++; if (busy !== 1'b0 || m0_done !== 1'b0 || m0_rdata !== 32'h0) begin bad++; $display("FAIL read_after got=%0h/%0h/%h exp=0/0/0", busy, m0_done, m0_rdata); end
    cyc();
  endtask
  task automatic test_round_robin();
    logic [5:0] eb, eg;
    eb = 6'b101010;
    eg = 6'b001000;
    rst = 1'b1;
    m0_addr = 32'hA0; m0_ren = 1'b1; m1_addr = 32'hB0; m1_ren = 1'b1;
    s_done = 1'b1; s_rdata = 32'h55;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      smp();
      total++; if (busy !== eb[i]) begin bad++; $display("FAIL rr_busy%0d got=%0h exp=%0h", i, busy, eb[i]); end
      if (eb[i]) begin
        total++; if (grant_id !== eg[i] || s_addr !== (eg[i] ? 32'hB0 : 32'hA0)) begin bad++; $display("FAIL rr_grant%0d got=%0h/%h exp=%0h", i, grant_id, s_addr, eg[i]); end
        total++; if (m0_done !== ~eg[i] || m1_done !== eg[i]) begin bad++; $display("FAIL rr_done%0d got=%0h/%0h exp=%0h/%0h", i, m0_done, m1_done, ~eg[i], eg[i]); end
      end
      cyc();
    end
    m0_ren = 1'b0; m1_ren = 1'b0; s_done = 1'b0;
    cyc();
  endtask
  task automatic test_timeout();
    m1_addr = 32'h40; m1_wdata = 32'hA5A5A5A5; m1_wmask = 4'b0011; m1_wen = 1'b1;
    m0_addr = 32'h777; m0_wdata = 32'h0BADF00D;
    smp();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL to_idle got=%0h exp=0", busy); end
    cyc();
    for (int i = 1; i <= 4; i++) begin
      smp();
      total++; if (busy !== 1'b1 || grant_id !== 1'b1) begin bad++; $display("FAIL to_busy%0d got=%0h/%0h exp=1/1", i, busy, grant_id); end
      if (i < 4) begin
        total++; if (s_wen !== 1'b1 || s_wdata !== 32'hA5A5A5A5 || s_wmask !== 4'b0011 || s_addr !== 32'h40) begin bad++; $display("FAIL to_fwd%0d got=%0h/%h/%h/%h exp=1/a5a5a5a5/3/40", i, s_wen, s_wdata, s_wmask, s_addr); end
        total++; if (m1_done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL to_early%0d got=%0h/%0h exp=0/0", i, m1_done, err); end
      end else begin
        total++; if (m1_done !== 1'b1 || m1_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL to_done got=%0h/%h exp=1/deadbeef", m1_done, m1_rdata); end
        total++; if (s_wen !== 1'b0 || s_ren !== 1'b0 || m0_done !== 1'b0) begin bad++; $display("FAIL to_force got=%0h/%0h/%0h exp=0/0/0", s_wen, s_ren, m0_done); end
      end
      cyc();
    end
    m1_wen = 1'b0;
    smp();
    total++; if (err !== 1'b1 || err_addr !== 32'h40 || busy !== 1'b0) begin bad++; $display("FAIL to_err got=%0h/%h/%0h exp=1/40/0", err, err_addr, busy); end
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    smp();
    total++; if (err !== 1'b0 || err_addr !== 32'h40) begin bad++; $display("FAIL to_clr got=%0h/%h exp=0/40", err, err_addr); end
  endtask
  task automatic test_done_at_timeout();
    cyc();
    m0_addr = 32'h200; m0_ren = 1'b1;
    cyc();
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) begin s_done = 1'b1; s_rdata = 32'hCAFEF00D; end
      smp();
      if (i == 4) begin
        total++; if (m0_done !== 1'b1 || m0_rdata !== 32'hCAFEF00D || s_ren !== 1'b1) begin bad++; $display("FAIL dt_done got=%0h/%h/%0h exp=1/cafef00d/1", m0_done, m0_rdata, s_ren); end
      end else begin
        total++; if (m0_done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL dt_wait%0d got=%0h/%0h exp=0/1", i, m0_done, busy); end
      end
      cyc();
    end
    m0_ren = 1'b0; s_done = 1'b0;
    smp();
    total++; if (err !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL dt_noerr got=%0h/%0h exp=0/0", err, busy); end
  endtask
  task automatic test_reset_mid();
    cyc();
    m0_addr = 32'h300; m0_ren = 1'b1;
    cyc();
    cyc();
    rst = 1'b1; s_done = 1'b1; s_rdata = 32'h77;
    smp();
    total++; if (m0_done !== 1'b0 || m0_rdata !== 32'h0) begin bad++; $display("FAIL rm_nodone got=%0h/%h exp=0/0", m0_done, m0_rdata); end
    cyc();
    rst = 1'b0; s_done = 1'b0; m1_addr = 32'h310; m1_ren = 1'b1;
    smp();
    total++; if (busy !== 1'b0 || s_ren !== 1'b0 || s_addr !== 32'h0 || grant_id !== 1'b0) begin bad++; $display("FAIL rm_idle got=%0h/%0h/%h/%0h exp=0", busy, s_ren, s_addr, grant_id); end
    total++; if (m0_done !== 1'b0 || m1_done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL rm_outs got=%0h/%0h/%0h exp=0", m0_done, m1_done, err); end
    cyc();
    s_done = 1'b1; s_rdata = 32'h88;
    smp();
    total++; if (busy !== 1'b1 || grant_id !== 1'b0 || s_addr !== 32'h300) begin bad++; $display("FAIL rm_first got=%0h/%0h/%h exp=1/0/300", busy, grant_id, s_addr); end
    total++; if (m0_done !== 1'b1 || m1_done !== 1'b0 || m0_rdata !== 32'h88) begin bad++; $display("FAIL rm_done got=%0h/%0h/%h exp=1/0/88", m0_done, m1_done, m0_rdata); end
    cyc();
    m0_ren = 1'b0; m1_ren = 1'b0; s_done = 1'b0;
  endtask
  task automatic test_abort();
    cyc();
    m0_addr = 32'h500; m0_ren = 1'b1;
    cyc();
    m1_addr = 32'h600; m1_ren = 1'b1;
    smp();
    total++; if (grant_id !== 1'b0 || s_addr !== 32'h500) begin bad++; $display("FAIL ab_own got=%0h/%h exp=0/500", grant_id, s_addr); end
    cyc();
    m0_ren = 1'b0;
    smp();
    total++; if (busy !== 1'b1 || m0_done !== 1'b0 || s_ren !== 1'b0) begin bad++; $display("FAIL ab_drop got=%0h/%0h/%0h exp=1/0/0", busy, m0_done, s_ren); end
    cyc();
    smp();
    total++; if (busy !== 1'b0 || m0_done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL ab_idle got=%0h/%0h/%0h exp=0/0/0", busy, m0_done, err); end
    cyc();
    s_done = 1'b1; s_rdata = 32'h99;
    smp();
    total++; if (busy !== 1'b1 || grant_id !== 1'b1 || s_addr !== 32'h600) begin bad++; $display("FAIL ab_m1 got=%0h/%0h/%h exp=1/1/600", busy, grant_id, s_addr); end
    total++; if (m1_done !== 1'b1 || m1_rdata !== 32'h99 || m0_done !== 1'b0) begin bad++; $display("FAIL ab_m1done got=%0h/%h/%0h exp=1/99/0", m1_done, m1_rdata, m0_done); end
    cyc();
    m1_ren = 1'b0; s_done = 1'b0;
  endtask
  initial begin
    test_reset();
    test_read();
    test_round_robin();
    test_timeout();
    test_done_at_timeout();
    test_reset_mid();
    test_abort();
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
